// File: rtl/pll_lock_supervisor.sv
// Supervisor for the rPLL on the free-running 27 MHz crystal clock: pulses PLL RESET,
// synchronises LOCK, qualifies it for stability and holds the PLL domains in reset until then.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RESET_CYCLES    = 27,
  parameter int LOCK_TIMEOUT_CYCLES = 27000,
  parameter int STABLE_CYCLES       = 2700,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       in_clk_27mhz,
  input  logic       in_rst,
  input  logic       in_pll_lock,
  output logic       out_pll_reset,
  output logic       out_sys_reset,
  output logic       out_ready,
  output logic       out_fault,
  output logic [7:0] out_relock_count,
  output logic [2:0] out_state
);

  localparam int MAX_AB  = (LOCK_TIMEOUT_CYCLES > STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > PLL_RESET_CYCLES) ? MAX_AB : PLL_RESET_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int RET_W   = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [RET_W-1:0] RET_LIMIT    = RET_W'(MAX_RETRIES);
  localparam logic [RET_W-1:0] RET_SAT      = {RET_W{1'b1}};
  localparam logic [RET_W-1:0] RET_ONE      = RET_W'(1);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RET_W-1:0]       retry_q, retry_d, retry_inc;
  logic [7:0]             relock_q, relock_d;
  logic                   pll_reset_q, pll_reset_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_s;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], in_pll_lock};
  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign retry_inc = (retry_q == RET_SAT) ? retry_q : retry_q + RET_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same clock.
        if (lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_inc;
          if (MAX_RETRIES != 0 && retry_inc == RET_LIMIT) state_d = ST_FAULT;
          else                                            state_d = ST_PLL_RST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_DONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d  = ST_PLL_RST;
          cnt_d    = '0;
          retry_d  = '0;
          relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_PLL_RST;
    endcase

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    pll_reset_d = (state_d == ST_PLL_RST);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge in_clk_27mhz or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= ST_PLL_RST;
      sync_q      <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign out_pll_reset    = pll_reset_q;
  assign out_sys_reset    = sys_reset_q;
  assign out_ready        = ready_q;
  assign out_fault        = fault_q;
  assign out_relock_count = relock_q;
  assign out_state        = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a timeline model turns each lock waveform into per-edge
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES         = 2;
  localparam int PLL_RESET_CYCLES    = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int STABLE_CYCLES       = 8;
  localparam int MAX_RETRIES         = 2;
  localparam int W                   = 15;

  localparam int S_RST   = 0;
  localparam int S_WAIT  = 1;
  localparam int S_STAB  = 2;
  localparam int S_RUN   = 3;
  localparam int S_FAULT = 4;

  logic       clk = 1'b0;
  logic       in_rst;
  logic       in_pll_lock;
  logic       out_pll_reset;
  logic       out_sys_reset;
  logic       out_ready;
  logic       out_fault;
  logic [7:0] out_relock_count;
  logic [2:0] out_state;
  logic [W-1:0] dut_vec;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit           lock_wave[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  // clock / reset
  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .SYNC_STAGES        (SYNC_STAGES),
    .PLL_RESET_CYCLES   (PLL_RESET_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .STABLE_CYCLES      (STABLE_CYCLES),
    .MAX_RETRIES        (MAX_RETRIES)
  ) dut (
    .in_clk_27mhz    (clk),
    .in_rst          (in_rst),
    .in_pll_lock     (in_pll_lock),
    .out_pll_reset   (out_pll_reset),
    .out_sys_reset   (out_sys_reset),
    .out_ready       (out_ready),
    .out_fault       (out_fault),
    .out_relock_count(out_relock_count),
    .out_state       (out_state)
  );

  assign dut_vec = {out_state, out_pll_reset, out_sys_reset, out_ready, out_fault, out_relock_count};

  // Output table: {state, pll_reset, sys_reset, ready, fault, relock_count}
  function automatic logic [W-1:0] pack(input int st, input int rc);
    logic [2:0] s3;
    logic [7:0] r8;
    s3 = st[2:0];
    r8 = rc[7:0];
    return {s3, st == S_RST, st != S_RUN, st == S_RUN, st == S_FAULT, r8};
  endfunction

  // Synchronised lock seen by the decision at edge e (edge 1 samples lock_wave[0]).
  function automatic bit ls(input int e);
    int i;
    i = e - SYNC_STAGES - 1;
    if (i < 0 || i >= lock_wave.size()) return 1'b0;
    return lock_wave[i];
  endfunction

  // Timeline model: each phase is resolved by scanning forward for the event that ends it.
  task automatic build_expect();
    int n, cur, st, nst, rc, nrc, retries, nxt;
    bit found;
    int st_a[];
    int rc_a[];
    n = lock_wave.size();
    st_a = new[n + 1];
    rc_a = new[n + 1];
    cur = 0; st = S_RST; rc = 0; retries = 0;
    st_a[0] = S_RST; rc_a[0] = 0;
    while (cur < n) begin
      nst = st; nrc = rc; nxt = n + 1; found = 1'b0;
      case (st)
        S_RST: begin
          nxt = cur + PLL_RESET_CYCLES;
          nst = S_WAIT;
        end
        S_WAIT: begin
          nxt = cur + LOCK_TIMEOUT_CYCLES;
          for (int i = cur + 1; i <= cur + LOCK_TIMEOUT_CYCLES; i++)
            if (!found && ls(i)) begin found = 1'b1; nxt = i; end
          if (found) nst = S_STAB;
          else begin
            retries++;
            nst = (MAX_RETRIES != 0 && retries == MAX_RETRIES) ? S_FAULT : S_RST;
          end
        end
        S_STAB: begin
          nxt = cur + STABLE_CYCLES + 1;
          nst = S_RUN;
          for (int i = cur + 1; i <= cur + STABLE_CYCLES + 1; i++)
            if (!found && !ls(i)) begin found = 1'b1; nxt = i; nst = S_WAIT; end
          if (!found) retries = 0;
        end
        S_RUN: begin
          for (int i = cur + 1; i <= n; i++)
            if (!found && !ls(i)) begin found = 1'b1; nxt = i; end
          nst = S_RST;
          nrc = (rc < 255) ? rc + 1 : 255;
          retries = 0;
        end
        default: nxt = n + 1;
      endcase
      for (int i = cur + 1; i < nxt && i <= n; i++) begin
        st_a[i] = st;
        rc_a[i] = rc;
      end
      if (nxt <= n) begin
        st_a[nxt] = nst;
        rc_a[nxt] = nrc;
      end
      cur = nxt; st = nst; rc = nrc;
    end
    for (int i = 0; i <= n; i++) exp_q.push_back(pack(st_a[i], rc_a[i]));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = dut_vec;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL out_vec t=%0t: got st=%0d prst=%b srst=%b rdy=%b flt=%b cnt=%0d, required st=%0d prst=%b srst=%b rdy=%b flt=%b cnt=%0d",
                 $time, mon_act[14:12], mon_act[11], mon_act[10], mon_act[9], mon_act[8], mon_act[7:0],
                 mon_exp[14:12], mon_exp[11], mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
      end
    end
  end

  // driver tasks
  task automatic add(input bit v, input int len);
    for (int i = 0; i < len; i++) lock_wave.push_back(v);
  endtask

  task automatic check_reset_vals(input string name);
    logic [W-1:0] want;
    want = pack(S_RST, 0);
    checks++;
    if (dut_vec !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, dut_vec, want);
    end
  endtask

  task automatic async_reset_check(input string name);
    @(posedge clk);
    #3;
    in_rst = 1'b1;
    #1;
    check_reset_vals({"async_rst ", name});
    in_pll_lock = 1'b0;
  endtask

  // Entered with in_rst high; releases it at a negedge and plays lock_wave edge by edge.
  task automatic run_case(input string name);
    int t;
    @(posedge clk);
    #1;
    build_expect();
    @(negedge clk);
    in_rst      = 1'b0;
    in_pll_lock = lock_wave[0];
    for (int k = 1; k < lock_wave.size(); k++) begin
      @(negedge clk);
      in_pll_lock = lock_wave[k];
    end
    t = 0;
    while (exp_q.size() > 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain %s: %0d expectations left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    lock_wave.delete();
    async_reset_check(name);
  endtask

  initial begin
    in_rst      = 1'b1;
    in_pll_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_state");

    add(0, 14); add(1, 30);
    run_case("lock_after_wait");

    add(0, PLL_RESET_CYCLES * 2 + LOCK_TIMEOUT_CYCLES * 2 + 10); add(1, 20);
    run_case("timeout_fault");

    add(0, 6); add(1, 6); add(0, 1); add(1, 30);
    run_case("stabilize_glitch");

    add(0, 6); add(1, 20);
    for (int r = 0; r < 300; r++) begin
      add(0, 1); add(1, 20);
    end
    run_case("relock_saturate");

    for (int r = 0; r < 8; r++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      while (lock_wave.size() < 200) begin
        add(v, $urandom_range(1, 45));
        v = !v;
      end
      run_case("random");
    end

    add(0, 14); add(1, 30);
    run_case("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises the Gowin rPLL that generates the 199.8/33.3 MHz clocks. Runs on the always-present 27 MHz crystal clock. Drives the PLL RESET input and synchronises the asynchronous LOCK output. Issues a clean system reset for the PLL-derived domains, with re-lock handling, retry, a timeout fault and a lock-loss counter.

Parameters:
SYNC_STAGES, 2, flip-flop stages on in_pll_lock (min 2)
PLL_RESET_CYCLES, 27, out_pll_reset pulse width in clocks (1 us at 27 MHz, min 1)
LOCK_TIMEOUT_CYCLES, 27000, max clocks in WAIT_LOCK before retry (1 ms)
STABLE_CYCLES, 2700, consecutive clocks synchronised lock must stay high before release (100 us)
MAX_RETRIES, 3, timeouts tolerated before FAULT; 0 = retry forever

Ports:
in_clk_27mhz  input  1  27 MHz crystal clock, free-running
in_rst  input  1  asynchronous, active-high reset
in_pll_lock  input  1  PLL LOCK, asynchronous to in_clk_27mhz
out_pll_reset  output  1  to PLL RESET, active-high
out_sys_reset  output  1  active-high reset for PLL-clocked logic (consumers re-synchronise deassertion locally)
out_ready  output  1  high only in RUN
out_fault  output  1  high only in FAULT
out_relock_count  output  8  lock-loss events seen in RUN, saturating at 255
out_state  output  3  0 PLL_RST, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT

Behaviour:
- Reset (in_rst=1, asynchronous): state=PLL_RST; out_pll_reset=1, out_sys_reset=1, out_ready=0, out_fault=0, out_relock_count=0; retry counter=0; phase counter=0; sync chain=0.
- lock_s is in_pll_lock after SYNC_STAGES flops. The FSM uses only lock_s.
- All outputs are registered and decoded from the current state. An output changes on the same edge that the state changes.
- PLL_RST: out_pll_reset=1 and out_sys_reset=1. The state lasts exactly PLL_RESET_CYCLES clocks, then goes to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: out_pll_reset=0 and out_sys_reset=1. The counter increments each clock.
  - If lock_s=1: go to STABILIZE and clear the counter.
  - Else, if the counter reaches LOCK_TIMEOUT_CYCLES-1: increment the retry counter. If MAX_RETRIES!=0 and the new retry count equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
  - If lock arrives on the same cycle as the timeout, lock wins.
- STABILIZE: out_sys_reset=1. The counter increments while lock_s=1.
  - If lock_s=0: go back to WAIT_LOCK with the counter cleared. No retry is consumed and no PLL reset is issued.
  - After STABLE_CYCLES consecutive high samples, go to RUN and clear the retry counter.
- RUN: out_sys_reset=0, out_ready=1.
  - If lock_s=0: go to PLL_RST. out_sys_reset=1 and out_ready=0 take effect on the same edge.
  - On that event, out_relock_count increments (saturating at 255) and the retry counter is cleared.
- FAULT: terminal until in_rst. out_fault=1, out_sys_reset=1, out_pll_reset=0. in_pll_lock is ignored.
- Latency: from the first in_clk_27mhz edge where in_pll_lock is sampled high in WAIT_LOCK, out_sys_reset deasserts exactly SYNC_STAGES+1+STABLE_CYCLES edges later.
- Loss latency: from in_pll_lock falling in RUN, out_sys_reset rises within SYNC_STAGES+1 edges.
- in_rst asserted mid-operation: outputs return to their reset values immediately (asynchronously). out_relock_count is cleared.
- Counter widths: sized to the largest of LOCK_TIMEOUT_CYCLES, STABLE_CYCLES and PLL_RESET_CYCLES. No wrap is possible because each compare terminates its count.

Test Plan (SYNC_STAGES=2, PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, STABLE_CYCLES=8, MAX_RETRIES=2):
1. Release in_rst with lock=0 -> out_pll_reset high exactly 4 clocks, then out_state=1, out_sys_reset=1.
2. Lock goes high 10 clocks into WAIT_LOCK and stays high -> out_state passes 2 then 3; out_sys_reset falls exactly 2+1+8=11 edges after lock is sampled; out_ready=1.
3. Lock held low -> after 32 clocks a 4-clock PLL reset, then WAIT_LOCK again. After the 2nd timeout -> out_state=4, out_fault=1, out_pll_reset=0. Lock high later -> no change until in_rst.
4. In STABILIZE, lock drops for 1 clock after 5 stable clocks -> return to WAIT_LOCK with no PLL reset; re-lock needs a full 8 stable clocks before RUN.
5. In RUN, lock drops -> out_sys_reset=1 within 3 edges, out_relock_count=1, 4-clock PLL reset, re-lock returns to RUN. Repeat 300 times -> count holds at 255.
6. Assert in_rst asynchronously in RUN, between clock edges -> outputs immediately at reset values, out_relock_count=0, then the sequence restarts as in scenario 1.
